// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Imported by the interface, the sequencer top and the return-address stack.
package pc_sequencer_pkg;

   localparam int          PC_W_DEF      = 20;
   localparam logic [19:0] RESET_PC_DEF  = 20'h00000;
   localparam int          RAS_DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALTED  = 3'd4
   } state_t;

   // Source of the next PC when EXECUTE completes.
   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_INC  = 2'd1,
      SEL_TGT  = 2'd2,
      SEL_RAS  = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/control bundle between the sequencer (master) and its environment (slave).
interface pc_sequencer_if #(
   parameter int PC_W = pc_sequencer_pkg::PC_W_DEF
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic            stall;
   logic            halt;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            call;
   logic            ret;
   logic            pc_load;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_out;
   logic [2:0]      state_o;
   logic            ras_err;

   modport master (
      output imem_req, imem_addr, pc_load, pc_next, pc_out, state_o, ras_err,
      input  imem_ack, stall, halt, branch_taken, branch_target, call, ret
   );

   modport slave (
      input  imem_req, imem_addr, pc_load, pc_next, pc_out, state_o, ras_err,
      output imem_ack, stall, halt, branch_taken, branch_target, call, ret
   );
endinterface

// File: rtl/pc_seq_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Push and pop are never requested in the same cycle by the sequencer.
module pc_seq_ras
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int DEPTH = RAS_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic [PC_W-1:0] i_push_data,
   output logic [PC_W-1:0] o_pop_data,
   output logic            o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [PTR_W-1:0] w_ptr_inc;
   logic [PTR_W-1:0] w_ptr_dec;

   // r_ptr is the next write slot, so the top of stack sits one below it.
   assign w_ptr_inc  = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
   assign w_ptr_dec  = (r_ptr == '0) ? PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
   assign o_pop_data = r_mem[w_ptr_dec];
   assign o_empty    = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push) begin
         r_mem[r_ptr] <= i_push_data;
         r_ptr        <= w_ptr_inc;
         if (r_cnt != CNT_W'(DEPTH)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (i_pop && !o_empty) begin
         r_ptr <= w_ptr_dec;
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch handshake, PC register and next-PC selection.
// Optional return-address stack is built when PC_SEQ_RAS_EN is defined.
//
// state      | meaning
// IDLE       | just out of reset, heads to FETCH on the next edge
// FETCH      | imem_req high at the current PC until imem_ack
// DECODE     | single-cycle decode slot
// EXECUTE    | waits out stall, then picks next PC or halts
// HALTED     | parked until reset
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W      = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
   parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   pc_sequencer_if.master     bus
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_pc_nxt;
   logic            w_exec_go;
   logic            w_ras_err;
   pc_sel_t         w_sel;

`ifdef PC_SEQ_RAS_EN
   logic            w_push;
   logic            w_pop;
   logic            w_ras_empty;
   logic [PC_W-1:0] w_ras_data;

   pc_seq_ras #(
      .PC_W  (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (w_pc_inc),
      .o_pop_data  (w_ras_data),
      .o_empty     (w_ras_empty)
   );
`endif

   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_exec_go = (r_state == ST_EXECUTE) && !bus.stall && !bus.halt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    w_state_nxt = ST_FETCH;
         ST_FETCH:   if (bus.imem_ack) w_state_nxt = ST_DECODE;
         ST_DECODE:  w_state_nxt = ST_EXECUTE;
         ST_EXECUTE: begin
            if (!bus.stall) begin
               w_state_nxt = bus.halt ? ST_HALTED : ST_FETCH;
            end
         end
         ST_HALTED:  w_state_nxt = ST_HALTED;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Priority below halt: ret > call > branch_taken > increment.
   always_comb begin
      w_sel     = SEL_HOLD;
      w_ras_err = 1'b0;
`ifdef PC_SEQ_RAS_EN
      w_push    = 1'b0;
      w_pop     = 1'b0;
`endif
      if (w_exec_go) begin
         if (bus.ret) begin
`ifdef PC_SEQ_RAS_EN
            if (w_ras_empty) begin
               w_sel     = SEL_INC;
               w_ras_err = 1'b1;
            end else begin
               w_sel = SEL_RAS;
               w_pop = 1'b1;
            end
`else
            w_sel = SEL_INC;
`endif
         end else if (bus.call) begin
            w_sel  = SEL_TGT;
`ifdef PC_SEQ_RAS_EN
            w_push = 1'b1;
`endif
         end else if (bus.branch_taken) begin
            w_sel = SEL_TGT;
         end else begin
            w_sel = SEL_INC;
         end
      end
   end

   always_comb begin
      w_pc_nxt = r_pc;
      case (w_sel)
         SEL_INC: w_pc_nxt = w_pc_inc;
         SEL_TGT: w_pc_nxt = bus.branch_target;
`ifdef PC_SEQ_RAS_EN
         SEL_RAS: w_pc_nxt = w_ras_data;
`endif
         default: w_pc_nxt = r_pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (w_exec_go) begin
         r_pc <= w_pc_nxt;
      end
   end

   // Request follows the async-reset state register, so it drops as soon as rst_n falls.
   assign bus.imem_req  = (r_state == ST_FETCH);
   assign bus.imem_addr = r_pc;
   assign bus.pc_load   = w_exec_go;
   assign bus.pc_next   = w_pc_nxt;
   assign bus.pc_out    = r_pc;
   assign bus.state_o   = r_state;
   assign bus.ras_err   = w_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues the expected load for each
// instruction, a negedge monitor checks every pc_load the DUT presents.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_W(20)) bus ();

   pc_sequencer #(
      .PC_W      (20),
      .RESET_PC  (20'h00000),
      .RAS_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [19:0] nxt;
      logic        err;
   } exp_t;

   typedef struct {
      int          aw;
      int          st;
      bit          h;
      bit          br;
      bit          cl;
      bit          rt;
      logic [19:0] tgt;
      logic [19:0] nxt;
      bit          err;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[$];
   exp_t        mon_e;
   logic [19:0] model_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.pc_load) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: pc_load=1 pc_next=%0h, required no load at %0t",
                     bus.pc_next, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pc_next", bus.pc_next, mon_e.nxt);
            chk("ras_err", bus.ras_err, mon_e.err);
         end
      end else if (rst_n && bus.ras_err) begin
         errors++;
         $display("FAIL ras_err_spurious: ras_err=1 without pc_load, required 0 at %0t", $time);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int aw, input int st, input bit h, input bit br, input bit cl,
                      input bit rt, input logic [19:0] tgt, input logic [19:0] nxt, input bit err);
      vec_t v;
      v.aw = aw; v.st = st; v.h = h; v.br = br; v.cl = cl; v.rt = rt;
      v.tgt = tgt; v.nxt = nxt; v.err = err;
      vecs.push_back(v);
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (bus.state_o != ST_FETCH && n < 20) begin
         tick();
         n++;
      end
      chk("reach_fetch", bus.state_o, ST_FETCH);
   endtask

   task automatic do_instr(input vec_t v);
      wait_fetch();
      chk("fetch_req", bus.imem_req, 1'b1);
      chk("fetch_addr", bus.imem_addr, model_pc);
      bus.imem_ack = 1'b0;
      repeat (v.aw) tick();
      chk("fetch_hold", bus.state_o, ST_FETCH);
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      chk("decode_state", bus.state_o, ST_DECODE);
      chk("decode_req", bus.imem_req, 1'b0);
      bus.halt          = v.h;
      bus.branch_taken  = v.br;
      bus.call          = v.cl;
      bus.ret           = v.rt;
      bus.branch_target = v.tgt;
      bus.stall         = (v.st > 0);
      if (!v.h) exp_q.push_back({v.nxt, v.err});
      tick();
      for (int i = 0; i < v.st; i++) begin
         chk("stall_state", bus.state_o, ST_EXECUTE);
         chk("stall_noload", bus.pc_load, 1'b0);
         tick();
         if (i == v.st - 1) bus.stall = 1'b0;
      end
      chk("exec_state", bus.state_o, ST_EXECUTE);
      tick();
      bus.halt = 1'b0; bus.branch_taken = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
      if (v.h) begin
         chk("halted_state", bus.state_o, ST_HALTED);
         chk("halt_pc", bus.pc_out, model_pc);
         repeat (5) begin
            bus.imem_ack = 1'b1;
            tick();
            chk("halt_req", bus.imem_req, 1'b0);
            chk("halt_stay", bus.state_o, ST_HALTED);
         end
         bus.imem_ack = 1'b0;
      end else begin
         model_pc = v.nxt;
         chk("back_fetch", bus.state_o, ST_FETCH);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, bus.state_o, ST_IDLE);
      chk({tag, "_req"}, bus.imem_req, 1'b0);
      chk({tag, "_pc"}, bus.pc_out, 20'h00000);
      chk({tag, "_pc_next"}, bus.pc_next, 20'h00000);
      chk({tag, "_load"}, bus.pc_load, 1'b0);
      chk({tag, "_ras_err"}, bus.ras_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0; bus.branch_taken = 1'b0;
      bus.call = 1'b0; bus.ret = 1'b0; bus.branch_target = '0;
      model_pc = 20'h00000;

      // Common prefix: increment, stalled branch, wrap, priority, call/return.
      add(1, 0, 0, 0, 0, 0, 20'h00000, 20'h00001, 0);
      add(0, 3, 0, 1, 0, 0, 20'h00100, 20'h00100, 0);
      add(2, 0, 0, 1, 0, 0, 20'hFFFFF, 20'hFFFFF, 0);
      add(0, 0, 0, 0, 0, 0, 20'h00000, 20'h00000, 0);
`ifdef PC_SEQ_RAS_EN
      add(0, 0, 0, 1, 1, 1, 20'h00777, 20'h00001, 1);
      add(0, 0, 0, 1, 1, 0, 20'h00ABC, 20'h00ABC, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00002, 0);
`else
      add(0, 0, 0, 1, 1, 1, 20'h00777, 20'h00001, 0);
      add(0, 0, 0, 1, 1, 0, 20'h00ABC, 20'h00ABC, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00ABD, 0);
`endif
      add(0, 0, 0, 1, 0, 0, 20'h00010, 20'h00010, 0);
      add(0, 0, 0, 0, 1, 0, 20'h00020, 20'h00020, 0);
      add(1, 0, 0, 0, 1, 0, 20'h00030, 20'h00030, 0);
      add(0, 0, 0, 0, 1, 0, 20'h00040, 20'h00040, 0);
      add(0, 1, 0, 0, 1, 0, 20'h00050, 20'h00050, 0);
      add(0, 0, 0, 0, 1, 0, 20'h00060, 20'h00060, 0);
`ifdef PC_SEQ_RAS_EN
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00051, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00041, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00031, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00021, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00022, 1);
`else
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00061, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00062, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00063, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00064, 0);
      add(0, 0, 0, 0, 0, 1, 20'h00000, 20'h00065, 0);
`endif
      add(0, 1, 0, 0, 1, 0, 20'h00200, 20'h00200, 0);
      add(0, 0, 1, 1, 0, 0, 20'h00300, 20'h00000, 0);

      #1 rst_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      chk("idle_after_release", bus.state_o, ST_IDLE);
      tick();
      chk("idle_to_fetch", bus.state_o, ST_FETCH);

      foreach (vecs[i]) do_instr(vecs[i]);

      // Reset from HALTED, then reset asserted in the middle of a fetch.
      rst_n = 1'b0;
      #1 check_reset_outputs("halt_rst");
      tick();
      rst_n = 1'b1;
      model_pc = 20'h00000;
      tick();
      begin
         vec_t v;
         v.aw = 0; v.st = 0; v.h = 0; v.br = 1; v.cl = 0; v.rt = 0;
         v.tgt = 20'h005A5; v.nxt = 20'h005A5; v.err = 0;
         do_instr(v);
      end
      wait_fetch();
      chk("midfetch_req_before", bus.imem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midfetch");
      tick();
      rst_n = 1'b1;
      model_pc = 20'h00000;
      tick();
      begin
         vec_t v;
         v.aw = 1; v.st = 0; v.h = 0; v.br = 0; v.cl = 0; v.rt = 0;
         v.tgt = 20'h00000; v.nxt = 20'h00001; v.err = 0;
         do_instr(v);
      end
      wait_fetch();
      chk("final_addr", bus.imem_addr, 20'h00001);
      repeat (2) tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 20: program-counter width in bits.
REQ-002 Parameter RESET_PC, default 20'h00000: PC value loaded by reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; used only when PC_SEQ_RAS_EN is defined.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port imem_req, output, 1: instruction-fetch request.
REQ-007 Port imem_addr, output, PC_W: fetch address; equals pc_out whenever imem_req=1.
REQ-008 Port imem_ack, input, 1: fetch-complete strobe from instruction memory.
REQ-009 Port stall, input, 1: hold execution in EXECUTE.
REQ-010 Port halt, input, 1: stop sequencing.
REQ-011 Port branch_taken, input, 1: take branch_target.
REQ-012 Port branch_target, input, PC_W: branch/call destination.
REQ-013 Port call, input, 1: subroutine call.
REQ-014 Port ret, input, 1: subroutine return.
REQ-015 Port pc_load, output, 1: load-enable (select) to the PC register.
REQ-016 Port pc_next, output, PC_W: data to the PC register.
REQ-017 Port pc_out, output, PC_W: current PC.
REQ-018 Port state_o, output, 3: current FSM state encoding.
REQ-019 Port ras_err, output, 1: one-cycle pulse on return-stack underflow.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE and HALTED.
REQ-021 IDLE SHALL move to FETCH on the first clock edge after rst_n deasserts.
REQ-022 FETCH SHALL hold imem_req=1 with imem_addr=pc_out until imem_ack=1, then move to DECODE; imem_req SHALL drop on the following cycle.
REQ-023 DECODE SHALL last exactly one cycle and then move to EXECUTE.
REQ-024 In EXECUTE with stall=1, the FSM SHALL remain in EXECUTE with pc_load=0; control inputs are ignored.
REQ-025 In EXECUTE with stall=0, control inputs SHALL be sampled with priority halt > ret > call > branch_taken > increment.
REQ-026 halt SHALL move the FSM to HALTED with pc_load=0; the PC is unchanged.
REQ-027 Every other EXECUTE exit SHALL assert pc_load for exactly one cycle with pc_next selected per REQ-025, then move to FETCH.
REQ-028 The increment path SHALL produce pc_next = pc_out+1 modulo 2^PC_W, so 20'hFFFFF wraps to 20'h00000.
REQ-029 branch_taken SHALL produce pc_next = branch_target.
REQ-030 Minimum instruction latency (imem_ack in the first FETCH cycle) SHALL be 3 cycles: FETCH to DECODE to EXECUTE.
REQ-031 HALTED SHALL be exited only by reset.
REQ-032 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-033 While rst_n=0: state=IDLE, pc_out=RESET_PC, imem_req=0, pc_load=0, pc_next=RESET_PC, ras_err=0, RAS emptied.
REQ-034 Reset asserted mid-fetch SHALL drop imem_req immediately, without waiting for a clock edge.

Configuration
REQ-035 With PC_SEQ_RAS_EN defined, the block SHALL include a RAS_DEPTH-entry circular return-address stack.
REQ-036 With PC_SEQ_RAS_EN, call SHALL push pc_out+1 and set pc_next=branch_target.
REQ-037 With PC_SEQ_RAS_EN, ret SHALL pop into pc_next.
REQ-038 With PC_SEQ_RAS_EN, a push when full SHALL overwrite the oldest entry.
REQ-039 With PC_SEQ_RAS_EN, ret when empty SHALL take the increment path and pulse ras_err.
REQ-040 Without PC_SEQ_RAS_EN, call SHALL behave as branch_taken, ret SHALL behave as increment, and ras_err SHALL be tied to 0.
REQ-041 All ports SHALL exist in both builds.

Structure
REQ-042 A shared package SHALL hold the state enum, PC_W and RESET_PC defaults.
REQ-043 The return-address stack SHALL be a sub-module, pc_seq_ras, instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-044 Reset release with RESET_PC=0 and imem_ack in the 2nd FETCH cycle: pc_load=1 with pc_next=1 in cycle 5, imem_addr=1 on the next FETCH.
REQ-045 pc_out=20'hFFFFF with increment: pc_next=20'h00000.
REQ-046 In EXECUTE, stall=1 for 3 cycles with branch_taken=1, target=20'h00100; stall then drops with branch_taken=1: pc_load asserts once, in the cycle stall=0, with pc_next=20'h00100.
REQ-047 halt=1 and branch_taken=1 in the same cycle: HALTED, pc_out unchanged, imem_req stays 0 until reset.
REQ-048 RAS build: 5 calls from PCs 10, 20, 30, 40, 50 followed by 5 rets: returns go to 51, 41, 31, 21, then the 5th ret gives pc_out+1 with ras_err=1.
REQ-049 rst_n=0 while imem_req=1 in FETCH: imem_req=0 and pc_out=RESET_PC before the next clock edge.
